// File: rtl/icache_refill_collector.sv
// Collects downstream refill beats into cachelines and queues them for the icache data array.
// Optional mid-line txnid consistency check: define ICACHE_REFILL_TXNID_CHK_EN.
module icache_refill_collector #(
   parameter int unsigned BEAT_WIDTH              = 256,
   parameter int unsigned BEATS_PER_LINE          = 2,
   parameter int unsigned FIFO_DEPTH              = 2,
   parameter int unsigned MSHR_ENTRY_INDEX_WIDTH  = 4,
   parameter int unsigned ICACHE_REQ_OPCODE_WIDTH = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   rxbeat_vld,
   output logic                                   rxbeat_rdy,
   input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]      rxbeat_txnid,
   input  logic [ICACHE_REQ_OPCODE_WIDTH-1:0]     rxbeat_opcode,
   input  logic [BEAT_WIDTH-1:0]                  rxbeat_data,
   output logic                                   line_vld,
   input  logic                                   line_rdy,
   output logic [MSHR_ENTRY_INDEX_WIDTH-1:0]      line_entry_idx,
   // downstream_rxdat_t layout: {opcode, line data}
   output logic [ICACHE_REQ_OPCODE_WIDTH+BEAT_WIDTH*BEATS_PER_LINE-1:0] line_pld,
   output logic                                   txnid_err
);

   localparam int unsigned LINE_WIDTH  = BEAT_WIDTH * BEATS_PER_LINE;
   localparam int unsigned PLD_WIDTH   = ICACHE_REQ_OPCODE_WIDTH + LINE_WIDTH;
   localparam int unsigned ENTRY_WIDTH = MSHR_ENTRY_INDEX_WIDTH + PLD_WIDTH;
   localparam int unsigned CNT_W       = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
   localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W       = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_LINE - 1);
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(FIFO_DEPTH);

   typedef enum logic {IDLE, FILL} state_t;
   state_t state, state_nxt;

   logic [CNT_W-1:0]                   beat_cnt;
   logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  txnid_q, push_txnid;
   logic [ICACHE_REQ_OPCODE_WIDTH-1:0] opcode_q, push_opcode;
   logic [LINE_WIDTH-1:0]              line_buf, line_asm;
   logic [ENTRY_WIDTH-1:0]             fifo_mem [FIFO_DEPTH];
   logic [ENTRY_WIDTH-1:0]             head;
   logic [PTR_W-1:0]                   wptr, rptr;
   logic [OCC_W-1:0]                   occ;
   logic                               first_beat, accept, last_beat, push, pop, full;

   // Ready comes from the registered occupancy only, so a pop never frees a slot for the same cycle.
   assign full       = (occ == FULL_OCC);
   assign rxbeat_rdy = !full;
   assign accept     = rxbeat_vld && rxbeat_rdy;
   assign last_beat  = (beat_cnt == LAST_BEAT);
   assign push       = accept && last_beat;
   assign line_vld   = (occ != '0);
   assign pop        = line_vld && line_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && !last_beat) state_nxt = FILL;
         FILL:    if (accept && last_beat)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      first_beat = (state == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
         txnid_q  <= '0;
         opcode_q <= '0;
      end else if (accept) begin
         beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
         if (first_beat) begin
            txnid_q  <= rxbeat_txnid;
            opcode_q <= rxbeat_opcode;
         end
      end
   end

   always_comb begin
      line_asm = line_buf;
      for (int unsigned k = 0; k < BEATS_PER_LINE; k++)
         if (beat_cnt == CNT_W'(k)) line_asm[k*BEAT_WIDTH +: BEAT_WIDTH] = rxbeat_data;
   end

   // A single-beat line pushes in the same cycle it would be latched, so bypass the latch.
   assign push_txnid  = first_beat ? rxbeat_txnid  : txnid_q;
   assign push_opcode = first_beat ? rxbeat_opcode : opcode_q;

   always_ff @(posedge clk) begin
      if (accept) line_buf <= line_asm;
      if (push)   fifo_mem[wptr] <= {push_txnid, push_opcode, line_asm};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else begin
         if (push) wptr <= (wptr == LAST_SLOT) ? '0 : wptr + 1'b1;
         if (pop)  rptr <= (rptr == LAST_SLOT) ? '0 : rptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   assign head           = fifo_mem[rptr];
   assign line_entry_idx = line_vld ? head[ENTRY_WIDTH-1 -: MSHR_ENTRY_INDEX_WIDTH] : '0;
   assign line_pld       = line_vld ? head[PLD_WIDTH-1:0] : '0;

`ifdef ICACHE_REFILL_TXNID_CHK_EN
   logic err_q;

   // Pulse appears the cycle after the offending beat is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= accept && !first_beat && (rxbeat_txnid != txnid_q);
   end

   assign txnid_err = err_q;
`else
   assign txnid_err = 1'b0;
`endif

endmodule
